// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator command sequencer.
// Status/command encodings match the calculator core interface.
package calc_pkg;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_PRINT = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'd10;
    localparam logic [3:0] CMD_SUB = 4'd11;
    localparam logic [3:0] CMD_MUL = 4'd12;
    localparam logic [3:0] CMD_EQ  = 4'd14;
    localparam logic [3:0] CMD_BS  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_WAIT,
        S_ERROR
    } seq_state_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// DEPTH x 4 synchronous FIFO with push/pop, full/empty, count and flush.
// Pointers wrap naturally because DEPTH is a power of two.
module calc_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [3:0]               push_data,
    input  logic                     pop,
    output logic [3:0]               pop_data,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_err
        $error("calc_cmd_fifo: DEPTH must be a power of two >= 2");
    end

    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign pop_data = mem_q[rd_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Next pointer/occupancy/storage; flush wins over any traffic.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_d = rd_q + 1'b1;
            end
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // FIFO state registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Paces buffered keypad codes onto the calculator cmd input.
// Optional WAIT watchdog enabled by defining CALC_SEQ_TIMEOUT_EN.
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int         DEPTH       = 4,
    parameter int         HOLD_CYCLES = 2,
    parameter logic [3:0] NOP_CMD     = 4'hD,
    parameter int         TIMEOUT     = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   key_valid,
    input  logic [3:0]             key_cmd,
    output logic                   key_ready,
    input  logic [1:0]             calc_status,
    output logic [3:0]             calc_cmd,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   seq_busy,
    output logic                   seq_err,
    output logic                   drop_pulse,
    input  logic                   clear_err
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15 || TIMEOUT < 1) begin : g_param_err
        $error("calc_cmd_sequencer: HOLD_CYCLES or TIMEOUT out of range");
    end

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    seq_state_t state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] issue_q, issue_d;
    logic       drop_q, drop_d;
    logic       fifo_push, fifo_pop, fifo_flush;
    logic       fifo_full, fifo_empty;
    logic [3:0] fifo_head;

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          wait_expired;

    assign wait_expired = (wait_cnt_q == TW'(TIMEOUT - 1));

    // WAIT watchdog counts cycles spent in WAIT, cleared everywhere else.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == S_WAIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic wait_expired;
    assign wait_expired = 1'b0;
`endif

    calc_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (key_cmd),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .flush     (fifo_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; status is only consulted in IDLE and WAIT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (calc_status == ST_ERR) begin
                    state_d = S_ERROR;
                end else if (!fifo_empty && calc_status != ST_BUSY) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (hold_q == '0) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (calc_status == ST_ERR) begin
                    state_d = S_ERROR;
                end else if (calc_status != ST_BUSY) begin
                    state_d = S_IDLE;
                end else if (wait_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_ERROR: begin
                if (clear_err) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and FIFO controls decoded from the current state.
    always_comb begin
        calc_cmd   = (state_q == S_ISSUE) ? issue_q : NOP_CMD;
        key_ready  = !fifo_full && (state_q != S_ERROR);
        seq_busy   = (state_q != S_IDLE);
        seq_err    = (state_q == S_ERROR);
        fifo_push  = key_valid && key_ready;
        fifo_pop   = (state_q == S_IDLE) && (state_d == S_ISSUE);
        fifo_flush = (state_q == S_ERROR);
        drop_pulse = drop_q;
    end

    // Issue register, hold countdown and refused-key pulse.
    always_comb begin
        issue_d = issue_q;
        hold_d  = hold_q;
        drop_d  = key_valid && !key_ready;
        if (fifo_pop) begin
            issue_d = fifo_head;
            hold_d  = HOLD_LOAD;
        end else if (state_q == S_ISSUE && hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            issue_q <= '0;
            hold_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            issue_q <= issue_d;
            hold_q  <= hold_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Self-checking bench for calc_cmd_sequencer.
// Issue order/timing is checked against a queue-based reference model.
module tb_calc_cmd_sequencer;
    import calc_pkg::*;

    localparam int         DEPTH = 4;
    localparam int         HOLD  = 2;
    localparam logic [3:0] NOP   = 4'hD;
    localparam int         TMO   = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_cmd = '0;
    logic [1:0] calc_status = ST_READY;
    logic       clear_err = 1'b0;
    logic       key_ready;
    logic [3:0] calc_cmd;
    logic [2:0] fifo_count;
    logic       seq_busy, seq_err, drop_pulse;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [3:0] prev_cmd = 4'hD;
    int         run = 0;
    logic [3:0] st_code[$];
    int         st_time[$];
    int         runs[$];
    int         max_cnt = 0;

    calc_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .NOP_CMD     (NOP),
        .TIMEOUT     (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_cmd     (key_cmd),
        .key_ready   (key_ready),
        .calc_status (calc_status),
        .calc_cmd    (calc_cmd),
        .fifo_count  (fifo_count),
        .seq_busy    (seq_busy),
        .seq_err     (seq_err),
        .drop_pulse  (drop_pulse),
        .clear_err   (clear_err)
    );

    always #5 clock = ~clock;

    // Advance to the next falling edge and log issue starts / hold lengths.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (calc_cmd !== NOP) begin
            if (prev_cmd === NOP) begin
                st_code.push_back(calc_cmd);
                st_time.push_back(cyc);
                run = 1;
            end else begin
                run++;
            end
        end else if (prev_cmd !== NOP) begin
            runs.push_back(run);
        end
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        prev_cmd = calc_cmd;
    endtask

    task automatic clear_log();
        st_code.delete();
        st_time.delete();
        runs.delete();
        max_cnt = int'(fifo_count);
    endtask

    function automatic logic [3:0] rand_key();
        logic [3:0] k;
        k = 4'($urandom_range(0, 14));
        if (k == 4'd13) k = CMD_BS;
        return k;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        vectors++;
        if (calc_cmd !== NOP) begin
            miscompares++;
            $display("FAIL reset_cmd: got %h want %h", calc_cmd, NOP);
        end
        vectors++;
        if (key_ready !== 1'b1 || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_ready_cnt: got %b/%0d want 1/0", key_ready, fifo_count);
        end
        vectors++;
        if ({seq_busy, seq_err, drop_pulse} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b%b%b want 000", seq_busy, seq_err, drop_pulse);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_issue_hold();
        int c0;
        clear_log();
        calc_status = ST_READY;
        tick();
        c0 = cyc;
        key_valid = 1'b1;
        key_cmd = 4'd7;
        tick();
        key_valid = 1'b0;
        vectors++;
        if (calc_cmd !== NOP || fifo_count !== 3'd1) begin
            miscompares++;
            $display("FAIL hold_written: got cmd %h cnt %0d want %h 1", calc_cmd, fifo_count, NOP);
        end
        repeat (8) tick();
        vectors++;
        if (st_code.size() != 1 || st_code[0] !== 4'd7) begin
            miscompares++;
            $display("FAIL hold_code: got %0d issues want one of 7", st_code.size());
        end
        vectors++;
        if ((st_time.size() > 0 ? st_time[0] : -1) != c0 + 2) begin
            miscompares++;
            $display("FAIL hold_latency: got %0d want %0d", st_time.size() > 0 ? st_time[0] - c0 : -1, 2);
        end
        vectors++;
        if ((runs.size() > 0 ? runs[0] : -1) != HOLD) begin
            miscompares++;
            $display("FAIL hold_len: got %0d want %0d", runs.size() > 0 ? runs[0] : -1, HOLD);
        end
    endtask

    task automatic test_pacing();
        logic [3:0] keys[4];
        int c0;
        keys = '{4'd1, CMD_ADD, 4'd2, CMD_EQ};
        clear_log();
        calc_status = ST_READY;
        tick();
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'b1;
            key_cmd = keys[i];
            tick();
        end
        key_valid = 1'b0;
        repeat (25) tick();
        vectors++;
        if (st_code.size() != 4) begin
            miscompares++;
            $display("FAIL pace_count: got %0d want 4", st_code.size());
        end
        for (int i = 0; i < 4 && i < st_code.size(); i++) begin
            vectors++;
            if (st_code[i] !== keys[i] || st_time[i] != c0 + 2 + i * (HOLD + 3)) begin
                miscompares++;
                $display("FAIL pace_issue%0d: got %h@%0d want %h@%0d", i, st_code[i], st_time[i] - c0, keys[i], 2 + i * (HOLD + 3));
            end
        end
        vectors++;
        if (max_cnt != 3) begin
            miscompares++;
            $display("FAIL pace_peak: got %0d want 3", max_cnt);
        end
    endtask

    task automatic test_full_drop();
        logic [3:0] keys[5];
        clear_log();
        calc_status = ST_BUSY;
        tick();
        for (int i = 0; i < 5; i++) begin
            keys[i] = rand_key();
            key_valid = 1'b1;
            key_cmd = keys[i];
            vectors++;
            if (key_ready !== (i < 4)) begin
                miscompares++;
                $display("FAIL full_ready%0d: got %b want %b", i, key_ready, i < 4);
            end
            tick();
        end
        key_valid = 1'b0;
        vectors++;
        if (drop_pulse !== 1'b1 || fifo_count !== 3'd4) begin
            miscompares++;
            $display("FAIL full_drop: got drop %b cnt %0d want 1 4", drop_pulse, fifo_count);
        end
        tick();
        vectors++;
        if (drop_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL full_drop_width: got %b want 0", drop_pulse);
        end
        calc_status = ST_READY;
        repeat (4 * (HOLD + 3) + 6) tick();
        vectors++;
        if (st_code.size() != 4) begin
            miscompares++;
            $display("FAIL full_issues: got %0d want 4", st_code.size());
        end
        for (int i = 0; i < 4 && i < st_code.size(); i++) begin
            vectors++;
            if (st_code[i] !== keys[i]) begin
                miscompares++;
                $display("FAIL full_code%0d: got %h want %h", i, st_code[i], keys[i]);
            end
        end
    endtask

    task automatic test_error();
        logic [3:0] a;
        clear_log();
        calc_status = ST_READY;
        tick();
        a = rand_key();
        key_valid = 1'b1;
        key_cmd = a;
        tick();
        key_valid = 1'b0;
        tick();
        vectors++;
        if (calc_cmd !== a) begin
            miscompares++;
            $display("FAIL err_issue: got %h want %h", calc_cmd, a);
        end
        calc_status = ST_BUSY;
        key_valid = 1'b1;
        key_cmd = rand_key();
        tick();
        key_cmd = rand_key();
        tick();
        key_valid = 1'b0;
        repeat (2) tick();
        vectors++;
        if (seq_busy !== 1'b1 || seq_err !== 1'b0 || fifo_count !== 3'd2) begin
            miscompares++;
            $display("FAIL err_wait: got busy %b err %b cnt %0d want 1 0 2", seq_busy, seq_err, fifo_count);
        end
        calc_status = ST_ERR;
        tick();
        vectors++;
        if (seq_err !== 1'b1 || key_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL err_enter: got err %b ready %b want 1 0", seq_err, key_ready);
        end
        tick();
        vectors++;
        if (fifo_count !== 3'd0 || calc_cmd !== NOP || seq_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_flush: got cnt %0d cmd %h err %b want 0 %h 1", fifo_count, calc_cmd, seq_err, NOP);
        end
        clear_err = 1'b1;
        calc_status = ST_READY;
        tick();
        clear_err = 1'b0;
        vectors++;
        if (seq_err !== 1'b0 || key_ready !== 1'b1 || seq_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: got err %b ready %b busy %b want 0 1 0", seq_err, key_ready, seq_busy);
        end
        repeat (6) tick();
        vectors++;
        if (st_code.size() != 1) begin
            miscompares++;
            $display("FAIL err_no_reissue: got %0d issues want 1", st_code.size());
        end
    endtask

    task automatic test_reset_mid_issue();
        clear_log();
        calc_status = ST_READY;
        tick();
        key_valid = 1'b1;
        key_cmd = 4'd9;
        tick();
        key_valid = 1'b0;
        tick();
        vectors++;
        if (calc_cmd !== 4'd9) begin
            miscompares++;
            $display("FAIL rst_issue: got %h want 9", calc_cmd);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (calc_cmd !== NOP || fifo_count !== 3'd0 || key_ready !== 1'b1
            || {seq_busy, seq_err, drop_pulse} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_mid: got cmd %h cnt %0d rdy %b flags %b%b%b want %h 0 1 000",
                     calc_cmd, fifo_count, key_ready, seq_busy, seq_err, drop_pulse, NOP);
        end
        reset = 1'b1;
        repeat (10) tick();
        vectors++;
        if (st_code.size() != 1) begin
            miscompares++;
            $display("FAIL rst_no_reissue: got %0d issues want 1", st_code.size());
        end
    endtask

    task automatic test_timeout();
        clear_log();
        calc_status = ST_READY;
        tick();
        key_valid = 1'b1;
        key_cmd = 4'd3;
        tick();
        key_valid = 1'b0;
        tick();
        calc_status = ST_BUSY;
`ifdef CALC_SEQ_TIMEOUT_EN
        repeat (10) tick();
        vectors++;
        if (seq_err !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_early: got %b want 0", seq_err);
        end
        tick();
        vectors++;
        if (seq_err !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_fire: got %b want 1", seq_err);
        end
        clear_err = 1'b1;
        calc_status = ST_READY;
        tick();
        clear_err = 1'b0;
        tick();
`else
        repeat (60) tick();
        vectors++;
        if (seq_busy !== 1'b1 || seq_err !== 1'b0 || calc_cmd !== NOP) begin
            miscompares++;
            $display("FAIL wait_forever: got busy %b err %b cmd %h want 1 0 %h", seq_busy, seq_err, calc_cmd, NOP);
        end
        calc_status = ST_READY;
        repeat (2) tick();
`endif
        vectors++;
        if (seq_busy !== 1'b0 || seq_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_release: got busy %b err %b want 0 0", seq_busy, seq_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] model[$];
        logic [3:0] pend_key;
        int occ;
        int done;
        int r;
        bit pend;
        bit exp_drop;
        occ = 0;
        done = 0;
        pend = 1'b0;
        exp_drop = 1'b0;
        pend_key = '0;
        clear_log();
        for (int n = 0; n < 560; n++) begin
            tick();
            if (pend) begin
                model.push_back(pend_key);
                occ++;
            end
            while (done < st_code.size()) begin
                vectors++;
                if (model.size() == 0 || st_code[done] !== model[0]) begin
                    miscompares++;
                    $display("FAIL rnd_order%0d: got %h want %h", done, st_code[done], model.size() > 0 ? model[0] : 4'hx);
                end
                if (model.size() > 0) void'(model.pop_front());
                occ--;
                if (done > 0) begin
                    vectors++;
                    if (st_time[done] - st_time[done-1] < HOLD + 3) begin
                        miscompares++;
                        $display("FAIL rnd_spacing%0d: got %0d want >=%0d", done, st_time[done] - st_time[done-1], HOLD + 3);
                    end
                end
                done++;
            end
            vectors++;
            if (int'(fifo_count) != occ) begin
                miscompares++;
                $display("FAIL rnd_count@%0d: got %0d want %0d", n, fifo_count, occ);
            end
            vectors++;
            if (key_ready !== (occ < DEPTH)) begin
                miscompares++;
                $display("FAIL rnd_ready@%0d: got %b want %b", n, key_ready, occ < DEPTH);
            end
            vectors++;
            if (drop_pulse !== exp_drop) begin
                miscompares++;
                $display("FAIL rnd_drop@%0d: got %b want %b", n, drop_pulse, exp_drop);
            end
            r = int'($urandom_range(0, 9));
            if (n < 480) begin
                key_valid = ($urandom_range(0, 9) < 6);
                calc_status = (r < 5) ? ST_READY : (r < 8) ? ST_BUSY : ST_PRINT;
            end else begin
                key_valid = 1'b0;
                calc_status = ST_READY;
            end
            key_cmd = rand_key();
            pend = key_valid && key_ready;
            pend_key = key_cmd;
            exp_drop = key_valid && !key_ready;
        end
        vectors++;
        if (model.size() != 0 || occ != 0) begin
            miscompares++;
            $display("FAIL rnd_drain: got %0d left occ %0d want 0 0", model.size(), occ);
        end
        for (int i = 0; i < runs.size(); i++) begin
            vectors++;
            if (runs[i] != HOLD) begin
                miscompares++;
                $display("FAIL rnd_hold%0d: got %0d want %0d", i, runs[i], HOLD);
            end
        end
    endtask

    initial begin
        test_reset();
        test_issue_hold();
        test_pacing();
        test_full_drop();
        test_error();
        test_reset_mid_issue();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
